// File: rtl/sha256_dbl_header_feeder.sv
// sha256_dbl_header_feeder
//   Drives a SHA256 core through a double hash of one 80-byte block header.
//   Pass 1 hashes the padded header as two chained blocks (B0 then B1).
//   Pass 2 hashes the padded 256-bit pass-1 result as one block (B2).
//   The final digest is returned together with a target-compare hit flag.
//
// Ports
//   CLK           clock
//   reset         synchronous, active-high reset
//   hdr_valid     header + target offered
//   hdr_ready     feeder idle and accepting a header
//   hdr           640-bit header, byte 0 = hdr[639:632]
//   target        256-bit difficulty target, big-endian numeric
//   sha_start     one-cycle start pulse to the core
//   sha_blk_type  2'd2 for header blocks (pass 1), 2'd0 for hash block (pass 2)
//   sha_msg       512-bit block to the core, word 0 = sha_msg[511:480]
//   sha_hash      256-bit core result, H0 = sha_hash[255:224]
//   sha_blk_done  one-cycle block-complete pulse from the core
//   digest        double-SHA256 result in core byte order
//   digest_valid  one-cycle pulse, digest/hit valid
//   hit           byte-reversed digest <= target
//   timeout_err   sticky core-timeout flag
//   busy          a pass is in progress
module sha256_dbl_header_feeder #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic         CLK,
    input  logic         reset,
    input  logic         hdr_valid,
    output logic         hdr_ready,
    input  logic [639:0] hdr,
    input  logic [255:0] target,
    output logic         sha_start,
    output logic [1:0]   sha_blk_type,
    output logic [511:0] sha_msg,
    input  logic [255:0] sha_hash,
    input  logic         sha_blk_done,
    output logic [255:0] digest,
    output logic         digest_valid,
    output logic         hit,
    output logic         timeout_err,
    output logic         busy
);

    localparam int unsigned CW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START1,
        S_WAIT_B0,
        S_WAIT_B1,
        S_START2,
        S_WAIT_H,
        S_OUTPUT,
        S_ERR
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [127:0]    hdr_tail;
    logic [255:0]    target_q;
    logic [CW-1:0]   to_cnt;
    logic [CW-1:0]   to_cnt_nxt;
    logic [CW-1:0]   to_cnt_inc;
    logic            in_wait;
    logic            to_expire;

    // Reverse the 32 bytes so the digest compares as a big-endian number.
    function automatic logic [255:0] byteswap32b(input logic [255:0] v);
        logic [255:0] r;
        r = '0;
        for (int unsigned i = 0; i < 32; i++) begin
            r[8*i +: 8] = v[255-8*i -: 8];
        end
        return r;
    endfunction

    always_comb begin
        state_nxt    = state;
        hdr_ready    = (state == S_IDLE);
        sha_start    = (state == S_START1) || (state == S_START2);
        digest_valid = (state == S_OUTPUT);
        timeout_err  = (state == S_ERR);
        busy         = (state != S_IDLE) && (state != S_ERR);
        in_wait      = (state == S_WAIT_B0) || (state == S_WAIT_B1) || (state == S_WAIT_H);

        to_cnt_inc = (to_cnt == CW'(TIMEOUT)) ? to_cnt : to_cnt + CW'(1);
        if (sha_start || sha_blk_done) begin
            to_cnt_nxt = '0;
        end else if (in_wait) begin
            to_cnt_nxt = to_cnt_inc;
        end else begin
            to_cnt_nxt = to_cnt;
        end
        // ERR is entered on the same edge the counter would reach TIMEOUT.
        to_expire = in_wait && !sha_blk_done && (to_cnt_inc == CW'(TIMEOUT));

        unique case (state)
            S_IDLE:    if (hdr_valid) state_nxt = S_START1;
            S_START1:  state_nxt = S_WAIT_B0;
            S_WAIT_B0: begin
                if (sha_blk_done)   state_nxt = S_WAIT_B1;
                else if (to_expire) state_nxt = S_ERR;
            end
            S_WAIT_B1: begin
                if (sha_blk_done)   state_nxt = S_START2;
                else if (to_expire) state_nxt = S_ERR;
            end
            S_START2:  state_nxt = S_WAIT_H;
            S_WAIT_H: begin
                if (sha_blk_done)   state_nxt = S_OUTPUT;
                else if (to_expire) state_nxt = S_ERR;
            end
            S_OUTPUT:  state_nxt = S_IDLE;
            S_ERR:     state_nxt = S_ERR;
            default:   state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (reset) begin
            state        <= S_IDLE;
            to_cnt       <= '0;
            sha_blk_type <= 2'd0;
            sha_msg      <= '0;
            digest       <= '0;
            hit          <= 1'b0;
            hdr_tail     <= '0;
            target_q     <= '0;
        end else begin
            state  <= state_nxt;
            to_cnt <= to_cnt_nxt;
            // B0 is loaded at accept, so only the header tail needs keeping for B1.
            unique case (state)
                S_IDLE: begin
                    if (hdr_valid) begin
                        sha_msg      <= hdr[639:128];
                        sha_blk_type <= 2'd2;
                        hdr_tail     <= hdr[127:0];
                        target_q     <= target;
                    end
                end
                S_WAIT_B0: begin
                    if (sha_blk_done) begin
                        sha_msg <= {hdr_tail, 8'h80, 312'b0, 64'd640};
                    end
                end
                S_WAIT_B1: begin
                    if (sha_blk_done) begin
                        sha_msg      <= {sha_hash, 8'h80, 184'b0, 64'd256};
                        sha_blk_type <= 2'd0;
                    end
                end
                S_WAIT_H: begin
                    if (sha_blk_done) begin
                        digest <= sha_hash;
                        hit    <= (byteswap32b(sha_hash) <= target_q);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
